// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential restoring divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
    localparam int DIV_N = 16;
    localparam int DIV_CW = $clog2(DIV_N);
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration (shift in a dividend bit, trial subtract).
module div_step #(
    parameter int N = 16
) (
    input  logic [N:0]   rem,
    input  logic         q_msb,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_next,
    output logic         q_bit
);
    logic [N+1:0] diff;
    // One guard bit above the N+1-bit trial so its sign is read off a single bit
    assign diff     = {rem, q_msb} - {2'b00, divisor};
    assign q_bit    = ~diff[N+1];
    assign rem_next = q_bit ? diff[N:0] : {rem[N-1:0], q_msb};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring unsigned divider, one quotient bit per clock, valid/ready on both sides.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N);
    div_state_t state, next;
    logic [CW-1:0] cnt;
    logic [N:0]    rem, rem_next;
    logic [N-1:0]  q, dsr;
    logic          dbz, q_bit;
    div_step #(.N(N)) u_step (
        .rem      (rem),
        .q_msb    (q[N-1]),
        .divisor  (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );
    always_comb begin
        next = state;
        if (state == IDLE)
            next = in_valid ? (divisor == '0 ? DONE : CALC) : IDLE;
        else if (state == CALC)
            next = cnt == '0 ? DONE : CALC;
        else
            next = out_ready ? IDLE : DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            q     <= '0;
            dsr   <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && in_valid) begin
                dsr <= divisor;
                cnt <= CW'(N - 1);
                q   <= divisor == '0 ? '1 : dividend;
                rem <= divisor == '0 ? {1'b0, dividend} : '0;
                dbz <= divisor == '0;
            end else if (state == CALC) begin
                rem <= rem_next;
                q   <= {q[N-2:0], q_bit};
                cnt <= cnt - 1'b1;
            end
        end
    end
    // Outputs come straight from registers; the quotient register doubles as the dividend shifter
    assign in_ready    = state == IDLE;
    assign out_valid   = state == DONE;
    assign quotient    = q;
    assign remainder   = rem[N-1:0];
    assign div_by_zero = dbz;
endmodule
